// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the system-ID word and build
// timestamp, compares them against expected constants and reports match/timeout.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h61C57CEA,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTOSTART      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic        busy,
  output logic        done,
  output logic        done_pulse
);

  localparam int unsigned DW   = 32;
  localparam int unsigned CNTW = 16;
  // Counter compare is done one bit wider so cnt+1 never wraps.
  localparam logic [CNTW:0] TO_LIMIT = (CNTW+1)'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ID_REQ  = 3'd1,
    S_ID_WAIT = 3'd2,
    S_TS_REQ  = 3'd3,
    S_TS_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              auto_q;
  logic              rd_q, rd_d;
  logic              addr_q, addr_d;
  logic [DW-1:0]     id_q, id_d;
  logic [DW-1:0]     ts_q, ts_d;
  logic              idm_q, idm_d;
  logic              tsm_q, tsm_d;
  logic              to_q, to_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pulse_q, pulse_d;

  logic in_req, in_wait, accept, capture, at_limit, expire, launch, enter_done, enter_req;

  // Transaction qualifiers shared by next-state and output logic.
  assign in_req   = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
  assign in_wait  = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
  assign accept   = in_req && !avm_waitrequest;
  assign capture  = (accept || in_wait) && avm_readdatavalid;
  assign at_limit = ({1'b0, cnt_q} + (CNTW+1)'(1)) == TO_LIMIT;
  assign expire   = (in_req || in_wait) && at_limit && !capture;
  assign launch   = (state_q == S_IDLE && (start || auto_q)) || (state_q == S_DONE && start);

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      auto_q  <= AUTOSTART;
      rd_q    <= 1'b0;
      addr_q  <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
      idm_q   <= 1'b0;
      tsm_q   <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      auto_q  <= 1'b0;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      idm_q   <= idm_d;
      tsm_q   <= tsm_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state: a capture on the acceptance cycle skips the WAIT state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start || auto_q) state_d = S_ID_REQ;
      S_ID_REQ: begin
        if (capture)     state_d = S_TS_REQ;
        else if (expire) state_d = S_DONE;
        else if (accept) state_d = S_ID_WAIT;
      end
      S_ID_WAIT: begin
        if (capture)     state_d = S_TS_REQ;
        else if (expire) state_d = S_DONE;
      end
      S_TS_REQ: begin
        if (capture || expire) state_d = S_DONE;
        else if (accept)       state_d = S_TS_WAIT;
      end
      S_TS_WAIT: if (capture || expire) state_d = S_DONE;
      S_DONE:    if (start) state_d = S_ID_REQ;
      default:   state_d = S_IDLE;
    endcase
  end

  assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);
  assign enter_req  = ((state_d == S_ID_REQ) || (state_d == S_TS_REQ)) && (state_d != state_q);

  // Output/datapath next values, registered alongside the state.
  always_comb begin
    cnt_d   = cnt_q;
    rd_d    = (state_d == S_ID_REQ) || (state_d == S_TS_REQ);
    addr_d  = addr_q;
    id_d    = id_q;
    ts_d    = ts_q;
    idm_d   = idm_q;
    tsm_d   = tsm_q;
    to_d    = to_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pulse_d = 1'b0;

    if (state_d == S_ID_REQ) addr_d = 1'b0;
    if (state_d == S_TS_REQ) addr_d = 1'b1;

    if (enter_req)                cnt_d = '0;
    else if (in_req || in_wait)   cnt_d = cnt_q + CNTW'(1);

    if (capture) begin
      if (state_q == S_ID_REQ || state_q == S_ID_WAIT) id_d = avm_readdata;
      else                                             ts_d = avm_readdata;
    end

    if (launch) begin
      idm_d  = 1'b0;
      tsm_d  = 1'b0;
      to_d   = 1'b0;
      done_d = 1'b0;
      busy_d = 1'b1;
    end

    // Match flags use the freshly captured words; a timeout forces them low.
    if (enter_done) begin
      to_d    = expire;
      idm_d   = !expire && (id_d == EXPECTED_ID);
      tsm_d   = !expire && (ts_d == EXPECTED_TS);
      done_d  = 1'b1;
      busy_d  = 1'b0;
      pulse_d = 1'b1;
    end
  end

  assign avm_read    = rd_q;
  assign avm_address = addr_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;
  assign id_match    = idm_q;
  assign ts_match    = tsm_q;
  assign timeout     = to_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_pulse  = pulse_q;

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its two readdata words: word 0 is the ID, word 1 is the build timestamp.
- After reset, or on request, it reads both words and compares them against expected values.
- It publishes the captured words, match flags and a timeout flag to the HPS-visible status logic and to boot-gating logic.

Parameters:
- EXPECTED_ID, 32'hACD51302, expected value of sysid word 0.
- EXPECTED_TS, 32'h61C57CEA, expected value of sysid word 1.
- TIMEOUT_CYCLES, 255, maximum cycles allowed per read transaction, counting request plus response phases; legal range 1..65535.
- AUTOSTART, 1, when 1 a check sequence launches automatically on the first cycle after reset deasserts.

Ports:
- clock  in  1  single system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a check sequence.
- avm_address  out  1  word select: 0 = ID, 1 = timestamp.
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall.
- avm_readdatavalid  in  1  response qualifier.
- avm_readdata  in  32  response data.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.
- id_match  out  1  id_value == EXPECTED_ID.
- ts_match  out  1  ts_value == EXPECTED_TS.
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES.
- busy  out  1  a sequence is in progress.
- done  out  1  level; a sequence has finished.
- done_pulse  out  1  one-cycle strobe when done rises.

Behaviour:
- Reset values: all outputs 0; id_value and ts_value are 0; state = IDLE; timeout counter = 0.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
- Launch:
  - IDLE->ID_REQ on start=1.
  - Also IDLE->ID_REQ on the first cycle after reset if AUTOSTART=1.
  - DONE->ID_REQ on start=1.
  - On launch, clear id_match, ts_match, timeout and done; set busy. id_value and ts_value hold their old contents until overwritten.
- start while busy=1 is ignored (no queuing).
- ID_REQ: avm_read=1, avm_address=0. avm_read and avm_address stay stable while avm_waitrequest=1. The request is accepted on the cycle where avm_read=1 and avm_waitrequest=0; the next state is ID_WAIT.
- ID_WAIT: avm_read=0, avm_address is held. On avm_readdatavalid=1, capture avm_readdata into id_value and go to TS_REQ.
- TS_REQ and TS_WAIT: identical to ID_REQ and ID_WAIT with avm_address=1; capture goes into ts_value. Exit from TS_WAIT is to DONE.
- Same-cycle response: if avm_readdatavalid=1 on the acceptance cycle itself (zero-latency fabric), capture immediately and skip the WAIT state. Required minimum sequence length: 2 request cycles, then done=1 on the following cycle.
- avm_readdatavalid arriving in IDLE, DONE or a REQ state before acceptance is ignored.
- Timeout:
  - A 16-bit counter clears on entry to each REQ state and increments every cycle in REQ and WAIT.
  - When the counter reaches TIMEOUT_CYCLES without a capture, set timeout=1, drop avm_read that same cycle, and go to DONE.
  - id_match and ts_match stay 0 on timeout; the remaining read is skipped.
- Entry to DONE:
  - id_match = (id_value == EXPECTED_ID), registered on the entry cycle using the captured values. Forced to 0 on timeout.
  - ts_match is computed the same way against EXPECTED_TS.
  - done=1, busy=0, done_pulse=1 for exactly one cycle.
- done, the match flags, id_value and ts_value hold until the next launch or reset.
- Reset mid-sequence: the next cycle returns to IDLE with all reset values and avm_read=0. An in-flight response is discarded. AUTOSTART re-launches after reset.
- avm_read is never asserted outside ID_REQ and TS_REQ. At most one outstanding read at any time.

Test Plan:
- Zero-wait slave returning 32'hACD51302 and 32'h61C57CEA with readdatavalid on the acceptance cycle, AUTOSTART=1 -> two reads at addresses 0 then 1; done and done_pulse at cycle 3 after reset release; id_match=1, ts_match=1, timeout=0.
- Slave with 3 waitrequest cycles and readdatavalid 2 cycles after acceptance -> avm_read and avm_address stable during stall; id_value and ts_value captured correctly; done_pulse exactly one cycle.
- Slave returns 32'h00000001 for word 0 and the correct timestamp -> id_match=0, ts_match=1, id_value=32'h00000001.
- TIMEOUT_CYCLES=8, waitrequest stuck high -> avm_read drops after 8 cycles; timeout=1, done=1, both match flags 0, no address-1 read.
- AUTOSTART=0, start pulsed twice during a sequence, then once after done -> exactly two sequences run; flags cleared at the second launch.
- reset asserted during ID_WAIT with a late readdatavalid delivered afterwards -> all outputs 0, late data ignored, AUTOSTART sequence then completes normally.
